// File: rtl/rx_pkg.sv
// ---------------------------------------------------------------------------
// rx_pkg
// Shared types and helpers for the receive stream buffer.
//   rx_state_e  : buffer occupancy state (EMPTY / PARTIAL / FULL).
//                 The 2'b11 encoding is unused and treated as illegal.
//   count_width : width of an occupancy counter able to hold 0..depth.
// ---------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [1:0] {
        RX_EMPTY   = 2'b00,
        RX_PARTIAL = 2'b01,
        RX_FULL    = 2'b10
    } rx_state_e;

    // Counter must represent the full value DEPTH, hence depth+1.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rx_stream_buffer_if.sv
// ---------------------------------------------------------------------------
// rx_stream_buffer_if
// Bundles the upstream and downstream handshake of rx_stream_buffer.
// Signal names are from the buffer's point of view (_i into, _o out of it).
//   flush_i  : synchronous clear of all buffered words
//   valid_i  / data_i / ready_o : upstream channel
//   valid_o  / data_o / ready_i : downstream channel
//   count_o  : number of buffered words
//
// Handshake: on either channel a word transfers on a rising clock edge
// exactly when valid and ready are both high in the preceding cycle. The
// sender holds valid and data stable until that transfer happens; ready
// may change freely and never depends combinationally on valid.
//
// Modports:
//   slave  : the buffer itself
//   master : the environment (upstream sender plus downstream consumer)
// ---------------------------------------------------------------------------
interface rx_stream_buffer_if
    import rx_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
);
    localparam int CW = count_width(DEPTH);

    logic             flush_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             ready_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             ready_i;
    logic [CW-1:0]    count_o;

    modport slave (
        input  flush_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, count_o
    );

    modport master (
        output flush_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, count_o
    );

endinterface

// File: rtl/rx_buffer_mem.sv
// ---------------------------------------------------------------------------
// rx_buffer_mem
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from the array)
// ---------------------------------------------------------------------------
module rx_buffer_mem #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_stream_buffer.sv
// ---------------------------------------------------------------------------
// rx_stream_buffer
// First-word-fall-through receive buffer of DEPTH words of WIDTH bits with
// valid/ready handshake on both sides. Occupancy is tracked by a 3-state
// FSM plus a registered count; full/empty are never derived from pointers.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : rx_stream_buffer_if.slave (flush, upstream, downstream, count)
//   state_o : current occupancy state, for observation
// ---------------------------------------------------------------------------
module rx_stream_buffer
    import rx_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rx_stream_buffer_if.slave  bus,
    output rx_state_e          state_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    rx_state_e        state_q,  state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ready;
    logic             valid;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rd_data;

    // Handshake outputs come from registered state only. The illegal
    // encoding decodes to neither ready nor valid, so no transfer can
    // happen while the FSM recovers to RX_EMPTY.
    always_comb begin
        ready = (state_q == RX_EMPTY)   || (state_q == RX_PARTIAL);
        valid = (state_q == RX_PARTIAL) || (state_q == RX_FULL);
        push  = bus.valid_i & ready & ~bus.flush_i;
        pop   = valid & bus.ready_i & ~bus.flush_i;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        if (bus.flush_i) begin
            // Flush wins over any handshake; storage keeps stale words.
            state_d  = RX_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                RX_EMPTY: begin
                    if (push) state_d = RX_PARTIAL;
                end
                RX_PARTIAL: begin
                    if (push && !pop && (count_q == CW'(DEPTH - 1))) begin
                        state_d = RX_FULL;
                    end else if (pop && !push && (count_q == CW'(1))) begin
                        state_d = RX_EMPTY;
                    end
                end
                RX_FULL: begin
                    // ready is low here, so only a pop can occur.
                    if (pop) state_d = RX_PARTIAL;
                end
                default: begin
                    state_d  = RX_EMPTY;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RX_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    rx_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign bus.ready_o = ready;
    assign bus.valid_o = valid;
    assign bus.data_o  = rd_data;
    assign bus.count_o = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rx_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_rx_stream_buffer
// Directed bench for rx_stream_buffer with WIDTH=8, DEPTH=4. Inputs change
// on the falling edge; outputs are observed on the falling edge, i.e. half a
// cycle after the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_rx_stream_buffer;
    import rx_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic      clk;
    logic      rst_n;
    rx_state_e state_dbg;
    int        checks;
    int        errors;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_word;

    rx_stream_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    rx_stream_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
    endtask

    task automatic drive_word(input logic [WIDTH-1:0] w);
        bus.valid_i = 1'b1;
        bus.data_i  = w;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", bus.ready_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.valid_o); end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
        checks++; if (state_dbg !== RX_EMPTY) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, RX_EMPTY); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({bus.ready_o, bus.valid_o, bus.count_o} !== 5'b10_000) begin
                errors++; $display("FAIL idle_%0d: got ready=%0b valid=%0b count=%0d expected 1/0/0", i, bus.ready_o, bus.valid_o, bus.count_o);
            end
        end
    endtask

    task automatic test_fill_backpressure();
        logic [WIDTH-1:0] words [4];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_word(words[i]);
            @(negedge clk);
            checks++; if (bus.count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", i, bus.count_o, i + 1); end
        end
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", bus.ready_o); end
        checks++; if (state_dbg !== RX_FULL) begin errors++; $display("FAIL full_state: got %0d expected %0d", state_dbg, RX_FULL); end
        // 0x55 offered while full must not be taken.
        drive_word(8'h55);
        repeat (2) @(negedge clk);
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d expected 4", bus.count_o); end
        checks++; if (bus.data_o !== 8'h11) begin errors++; $display("FAIL full_head: got %0h expected 11", bus.data_o); end
        // Release the consumer; 0x55 enters on the edge after ready_o returns.
        bus.ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd3 || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL drain_1: got count=%0d ready=%0b expected 3/1", bus.count_o, bus.ready_o);
        end
        checks++; if (bus.data_o !== 8'h22) begin errors++; $display("FAIL drain_1_data: got %0h expected 22", bus.data_o); end
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL drain_2_count: got %0d expected 3", bus.count_o); end
        checks++; if (bus.data_o !== 8'h33) begin errors++; $display("FAIL drain_2_data: got %0h expected 33", bus.data_o); end
        @(negedge clk);
        checks++; if (bus.data_o !== 8'h44 || bus.count_o !== 3'd2) begin
            errors++; $display("FAIL drain_3: got data=%0h count=%0d expected 44/2", bus.data_o, bus.count_o);
        end
        @(negedge clk);
        checks++; if (bus.data_o !== 8'h55 || bus.count_o !== 3'd1) begin
            errors++; $display("FAIL drain_4: got data=%0h count=%0d expected 55/1", bus.data_o, bus.count_o);
        end
        @(negedge clk);
        checks++; if (bus.valid_o !== 1'b0 || bus.count_o !== 3'd0) begin
            errors++; $display("FAIL drain_empty: got valid=%0b count=%0d expected 0/0", bus.valid_o, bus.count_o);
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.ready_i = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                checks++; if (bus.count_o !== 3'd1 || bus.valid_o !== 1'b1) begin
                    errors++; $display("FAIL stream_occ_%0d: got count=%0d valid=%0b expected 1/1", i, bus.count_o, bus.valid_o);
                end
                exp_word = exp_q.pop_front();
                checks++; if (bus.data_o !== exp_word) begin
                    errors++; $display("FAIL stream_data_%0d: got %0h expected %0h", i, bus.data_o, exp_word);
                end
            end
            if (i < 16) begin
                checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %0b expected 1", i, bus.ready_o); end
                drive_word(8'(i));
                exp_q.push_back(8'(i));
            end else begin
                bus.valid_i = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (bus.count_o !== 3'd0 || exp_q.size() != 0) begin
            errors++; $display("FAIL stream_end: got count=%0d left=%0d expected 0/0", bus.count_o, exp_q.size());
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        bus.ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_word(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            checks++; if (bus.count_o !== 3'd2) begin errors++; $display("FAIL wrap_count_%0d: got %0d expected 2", j, bus.count_o); end
            exp_word = exp_q.pop_front();
            checks++; if (bus.data_o !== exp_word) begin errors++; $display("FAIL wrap_data_%0d: got %0h expected %0h", j, bus.data_o, exp_word); end
            drive_word(8'hB0 + 8'(j));
            exp_q.push_back(8'hB0 + 8'(j));
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        for (int k = 2; k > 0; k--) begin
            checks++; if (bus.count_o !== 3'(k)) begin errors++; $display("FAIL wrap_drain_count_%0d: got %0d expected %0d", k, bus.count_o, k); end
            exp_word = exp_q.pop_front();
            checks++; if (bus.data_o !== exp_word) begin errors++; $display("FAIL wrap_drain_data_%0d: got %0h expected %0h", k, bus.data_o, exp_word); end
            @(negedge clk);
        end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL wrap_empty: got %0b expected 0", bus.valid_o); end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_flush();
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_word(8'hD0 + 8'(i));
            @(negedge clk);
        end
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", bus.count_o); end
        bus.flush_i = 1'b1;
        drive_word(8'h99);
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        checks++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_clear: got count=%0d valid=%0b ready=%0b expected 0/0/1", bus.count_o, bus.valid_o, bus.ready_o);
        end
        // Pointers restart at 0: a fresh word must be the one presented.
        drive_word(8'h77);
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (bus.count_o !== 3'd1 || bus.data_o !== 8'h77) begin
            errors++; $display("FAIL flush_after: got count=%0d data=%0h expected 1/77", bus.count_o, bus.data_o);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL flush_drain: got %0d expected 0", bus.count_o); end
    endtask

    task automatic test_async_reset();
        bus.ready_i = 1'b0;
        drive_word(8'hC1);
        @(negedge clk);
        drive_word(8'hC2);
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (bus.count_o !== 3'd2) begin errors++; $display("FAIL areset_pre: got %0d expected 2", bus.count_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.valid_o !== 1'b0 || bus.count_o !== 3'd0 || bus.ready_o !== 1'b1) begin
            errors++; $display("FAIL areset_now: got valid=%0b count=%0d ready=%0b expected 0/0/1", bus.valid_o, bus.count_o, bus.ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_word(8'h5A);
        @(negedge clk);
        bus.valid_i = 1'b0;
        checks++; if (bus.count_o !== 3'd1 || bus.valid_o !== 1'b1 || bus.data_o !== 8'h5A) begin
            errors++; $display("FAIL areset_resume: got count=%0d valid=%0b data=%0h expected 1/1/5a", bus.count_o, bus.valid_o, bus.data_o);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        bus.ready_i = 1'b0;
        checks++; if (bus.count_o !== 3'd0 || state_dbg !== RX_EMPTY) begin
            errors++; $display("FAIL areset_drain: got count=%0d state=%0d expected 0/0", bus.count_o, state_dbg);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill_backpressure();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
